// File: rtl/uart_gpio_pkg.sv
// uart_gpio_pkg
// Shared definitions for the MCU-to-fabric UART receive path:
//   - rx_state_t    receiver state encoding
//   - calc_cpb()    clocks-per-bit from clock frequency and line rate
//   - DEFAULT_BAUD  default line rate
//   - DATA_W        byte width carried through the receive FIFO
package uart_gpio_pkg;

  localparam int DEFAULT_BAUD = 115200;
  localparam int DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic int calc_cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_gpio_fifo.sv
// uart_gpio_fifo
// Small circular receive buffer. Pointers carry one extra wrap bit so that
// full and empty are told apart by the pointer MSBs.
// Ports:
//   ppm_clk, ppm_rst  clock, synchronous active-high reset
//   push, push_data   write request and byte
//   pop               read request (ignored while empty)
//   head              byte at the read pointer
//   not_empty         at least one byte stored
//   drop              combinational: this cycle's push is being discarded
module uart_gpio_fifo
  import uart_gpio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              ppm_clk,
  input  logic              ppm_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              not_empty,
  output logic              drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign not_empty = !empty;

  always_ff @(posedge ppm_clk) begin
    if (ppm_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_gpio_rx.sv
// uart_gpio_rx
// Receive end of the MCU-to-fabric UART link carried on GPIO H0. The pin is
// treated as idle-high whenever the MCU output driver is disabled.
// Optional feature macro: UART_GPIO_RX_PARITY_EN (even parity bit between
// data and stop, adds the parity_err output).
// Ports:
//   ppm_clk, ppm_rst           clock, synchronous active-high reset
//   gpio_h0_out, gpio_h0_oe_n  MCU serial data and active-low output enable
//   rx_data, rx_valid,
//   rx_ready                   FIFO head byte with valid/ready handshake
//   frame_err                  1-cycle pulse: stop bit sampled low
//   overrun                    1-cycle pulse: byte dropped, FIFO full
//   parity_err                 (parity build) 1-cycle pulse: parity mismatch
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a falling edge on line_s
// START     | half a bit in, confirming the start bit is still low
// DATA      | sampling 8 data bits, LSB first, one per CPB cycles
// PARITY    | sampling the even parity bit (parity build only)
// STOP      | sampling the stop bit; push byte or flag a framing error
// WAIT_HIGH | after a framing error, waiting for the line to go idle
module uart_gpio_rx
  import uart_gpio_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       ppm_clk,
  input  logic       ppm_rst,
  input  logic       gpio_h0_out,
  input  logic       gpio_h0_oe_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_GPIO_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CPB   = calc_cpb(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);

  rx_state_t  state;
  rx_state_t  state_nx;

  logic       sync1;
  logic       line_s;
  logic       line_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;

  logic       cnt_clr;
  logic       bit_clr;
  logic       take_bit;
  logic       push;
  logic       ferr_set;
  logic       fifo_drop;
  logic       par_bad;
`ifdef UART_GPIO_RX_PARITY_EN
  logic       par_sample;
`endif

  always_ff @(posedge ppm_clk) begin
    if (ppm_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    bit_clr  = 1'b0;
    take_bit = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_GPIO_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (line_prev && !line_s) begin
          state_nx = START;
          cnt_clr  = 1'b1;
          bit_clr  = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          if (line_s) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
            cnt_clr  = 1'b1;
          end
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          take_bit = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_GPIO_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_GPIO_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_LAST) begin
          par_sample = 1'b1;
          cnt_clr    = 1'b1;
          state_nx   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == FULL_LAST) begin
          if (line_s) begin
            push     = !par_bad;
            state_nx = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_nx = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (line_s) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // line_prev follows line_s in every state so a start edge can be taken
  // in the very first IDLE cycle after a stop sample.
  always_ff @(posedge ppm_clk) begin
    if (ppm_rst) begin
      sync1     <= 1'b1;
      line_s    <= 1'b1;
      line_prev <= 1'b1;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1     <= gpio_h0_oe_n | gpio_h0_out;
      line_s    <= sync1;
      line_prev <= line_s;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (take_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (take_bit) begin
        shreg <= {line_s, shreg[7:1]};
      end
      frame_err <= ferr_set;
      overrun   <= fifo_drop;
    end
  end

`ifdef UART_GPIO_RX_PARITY_EN
  // Even parity: data bits XOR parity bit must be zero. A bad byte is
  // remembered until the stop sample so the push can be suppressed there.
  always_ff @(posedge ppm_clk) begin
    if (ppm_rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_sample && ((^shreg) ^ line_s);
      if (bit_clr) begin
        par_bad <= 1'b0;
      end else if (par_sample) begin
        par_bad <= (^shreg) ^ line_s;
      end
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  uart_gpio_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ppm_clk   (ppm_clk),
    .ppm_rst   (ppm_rst),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_ready),
    .head      (rx_data),
    .not_empty (rx_valid),
    .drop      (fifo_drop)
  );

endmodule

// File: tb/tb_uart_gpio_rx.sv
module tb_uart_gpio_rx;

  localparam int CPB = 50_000_000 / 115200;
`ifdef UART_GPIO_RX_PARITY_EN
  localparam int EXP_LAT = 4126 + CPB;
`else
  localparam int EXP_LAT = 4126;
`endif

  logic       ppm_clk = 1'b0;
  logic       ppm_rst;
  logic       gpio_h0_out;
  logic       gpio_h0_oe_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
`ifdef UART_GPIO_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad   = 0;
  int hs_cnt  = 0;
  int ferr_hi = 0;
  int ovr_hi  = 0;
  int perr_hi = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  always #5 ppm_clk = ~ppm_clk;

  uart_gpio_rx dut (
    .ppm_clk      (ppm_clk),
    .ppm_rst      (ppm_rst),
    .gpio_h0_out  (gpio_h0_out),
    .gpio_h0_oe_n (gpio_h0_oe_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun)
`ifdef UART_GPIO_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  // Scoreboard monitor: every accepted byte is compared with the queue head.
  always @(negedge ppm_clk) begin
    if (!ppm_rst) begin
      if (frame_err) ferr_hi++;
      if (overrun) ovr_hi++;
`ifdef UART_GPIO_RX_PARITY_EN
      if (parity_err) perr_hi++;
`endif
      if (rx_valid && rx_ready) begin
        total++;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected got=%02h want=none", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rx_data !== mon_exp) begin
            bad++;
            $display("FAIL rx_data got=%02h want=%02h", rx_data, mon_exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after CPB cycles.
  task automatic send_bit(input logic v);
    gpio_h0_out = v;
    repeat (CPB) @(posedge ppm_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_GPIO_RX_PARITY_EN
    send_bit(par_b);
`endif
    send_bit(stop_b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ppm_clk);
    #1;
  endtask

  int lat;
  int hs0;
  int ferr0;
  int perr0;

  initial begin
    ppm_rst      = 1'b1;
    gpio_h0_out  = 1'b1;
    gpio_h0_oe_n = 1'b0;
    rx_ready     = 1'b1;
    idle(5);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    ppm_rst = 1'b0;
    idle(10);

    // 0xA5 with latency measurement from the pin falling edge.
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1, ^8'hA5);
      begin
        while (lat < 6000) begin
          @(posedge ppm_clk);
          #1;
          lat++;
          if (rx_valid) break;
        end
        check("latency", lat, EXP_LAT);
        idle(1);
        check("valid_one_cycle", rx_valid, 0);
      end
    join
    idle(20);
    check("a5_delivered", hs_cnt, 1);

    // Output enable off: a low pin must be ignored.
    hs0 = hs_cnt;
    gpio_h0_oe_n = 1'b1;
    idle(1);
    gpio_h0_out = 1'b0;
    idle(1000);
    gpio_h0_out = 1'b1;
    idle(1);
    gpio_h0_oe_n = 1'b0;
    idle(20);
    check("oe_off_no_rx", hs_cnt, hs0);
    check("oe_off_no_ferr", ferr_hi, 0);

    // Framing error followed by a break, then a good byte.
    send_byte(8'h3C, 1'b0, ^8'h3C);
    idle(5000);
    gpio_h0_out = 1'b1;
    idle(50);
    check("break_one_ferr", ferr_hi, 1);
    check("break_no_push", hs_cnt, hs0);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, ^8'h55);
    idle(20);
    check("after_break_rx", hs_cnt, hs0 + 1);

    // Short glitch rejected in START.
    hs0 = hs_cnt;
    gpio_h0_out = 1'b0;
    idle(100);
    gpio_h0_out = 1'b1;
    idle(1000);
    check("glitch_no_rx", hs_cnt, hs0);
    check("glitch_no_ferr", ferr_hi, 1);

    // Reset in the middle of a frame discards it.
    fork
      send_byte(8'hFF, 1'b1, 1'b1);
      begin
        idle(1500);
        ppm_rst = 1'b1;
        idle(2);
        ppm_rst = 1'b0;
      end
    join
    idle(50);
    check("midreset_no_rx", hs_cnt, hs0);
    check("midreset_valid", rx_valid, 0);
    check("midreset_no_ferr", ferr_hi, 1);

    // Fill FIFO with consumer stalled; fifth byte overruns.
    rx_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1, ^(8'(b)));
    end
    idle(10);
    check("overrun_one_pulse", ovr_hi, 1);
    check("stall_valid", rx_valid, 1);
    check("stall_head", rx_data, 8'h01);
    check("stall_no_hs", hs_cnt, hs0);
    rx_ready = 1'b1;
    idle(10);
    check("drain_count", hs_cnt, hs0 + 4);
    check("drain_valid_low", rx_valid, 0);

`ifdef UART_GPIO_RX_PARITY_EN
    hs0   = hs_cnt;
    perr0 = perr_hi;
    send_byte(8'h07, 1'b1, 1'b0);
    idle(20);
    check("parity_bad_pulse", perr_hi, perr0 + 1);
    check("parity_bad_no_push", hs_cnt, hs0);
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b1, 1'b1);
    idle(20);
    check("parity_good_rx", hs_cnt, hs0 + 1);
    check("parity_good_no_pulse", perr_hi, perr0 + 1);
`endif

    ferr0 = ferr_hi;
    check("final_ferr", ferr0, 1);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
